// File: rtl/mux_5b.sv
// 2:1 selector for the MIPS datapath (e.g. rt vs rd write destination).
// Gives the selected value combinationally and as a registered copy with a valid flag.
module mux_5b #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             signal,
  input  logic             en,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
  output logic             valid_q
);

  assign result = signal ? input_b : input_a;

  // valid_q marks only the cycle right after an enabled capture; result_q holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (en) begin
        result_q <= result;
      end
      valid_q <= en;
    end
  end

endmodule

// File: tb/tb_mux_5b.sv
// Self-checking bench for mux_5b: a reference model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_mux_5b;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] input_a = '0;
  logic [WIDTH-1:0] input_b = '0;
  logic             signal = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;

  int checks = 0;
  int errors = 0;

  mux_5b #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .input_a  (input_a),
    .input_b  (input_b),
    .signal   (signal),
    .en       (en),
    .result   (result),
    .result_q (result_q),
    .valid_q  (valid_q)
  );

  always #5 clk = ~clk;

  // Reference model: pick from a two-entry table, remember the last enabled pick
  logic [WIDTH-1:0] model_q;
  logic             model_v;
  bit               q_known = 1'b0;

  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic s);
    logic [WIDTH-1:0] table_v [2];
    table_v[0] = a;
    table_v[1] = b;
    return table_v[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q <= '0;
      model_v <= 1'b0;
      q_known <= 1'b1;
    end else if (en) begin
      model_q <= pick(input_a, input_b, signal);
      model_v <= 1'b1;
    end else begin
      model_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (result !== pick(input_a, input_b, signal)) begin
      errors++;
      $display("[TB] FAIL model_result t=%0t actual=%b required=%b", $time, result,
               pick(input_a, input_b, signal));
    end
    if (q_known) begin
      checks++;
      if (result_q !== model_q || valid_q !== model_v) begin
        errors++;
        $display("[TB] FAIL model_registered t=%0t actual=%b/%b required=%b/%b", $time,
                 result_q, valid_q, model_q, model_v);
      end
    end
  end

  task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s t=%0t actual=%b required=%b", name, $time, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, input logic e);
    input_a = a;
    input_b = b;
    signal  = s;
    en      = e;
  endtask

  initial begin
    logic prev_sel;

    // Combinational select without any clock dependence
    apply_stimulus(5'b00001, 5'b00111, 1'b0, 1'b0);
    #1 check_output("sel_a", result, 5'b00001);
    #100 signal = 1'b1;
    #1 check_output("sel_b", result, 5'b00111);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_result_q", result_q, 5'd0);
    check_output("rst_valid_q", {4'd0, valid_q}, 5'd0);
    check_output("rst_result", result, 5'b00111);

    // Registered capture
    apply_stimulus(5'd3, 5'd28, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("cap_a", result_q, 5'd3);
    check_output("cap_a_valid", {4'd0, valid_q}, 5'd1);
    signal = 1'b1;
    @(posedge clk);
    #1;
    check_output("cap_b", result_q, 5'd28);
    check_output("cap_b_valid", {4'd0, valid_q}, 5'd1);

    // Enable low holds the register and drops valid
    apply_stimulus(5'd3, 5'd31, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_output("hold_q", result_q, 5'd28);
    check_output("hold_valid", {4'd0, valid_q}, 5'd0);
    check_output("hold_comb_a", result, 5'd3);
    signal = 1'b1;
    #1 check_output("hold_comb_b", result, 5'd31);
    repeat (2) @(posedge clk);
    #1;
    check_output("hold_q_3", result_q, 5'd28);
    check_output("hold_valid_3", {4'd0, valid_q}, 5'd0);

    // Extremes and equal inputs
    @(posedge clk);
    #1 apply_stimulus(5'b00000, 5'b11111, 1'b0, 1'b0);
    #1 check_output("ext_zero", result, 5'b00000);
    signal = 1'b1;
    #1 check_output("ext_ones", result, 5'b11111);
    apply_stimulus(5'b10101, 5'b10101, 1'b0, 1'b0);
    #1 check_output("eq_s0", result, 5'b10101);
    signal = 1'b1;
    #1 check_output("eq_s1", result, 5'b10101);

    // Signal toggling every enabled cycle, then a half-cycle reset pulse
    @(posedge clk);
    #1 apply_stimulus(5'd9, 5'd22, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      prev_sel = signal;
      @(posedge clk);
      #1;
      check_output("toggle_q", result_q, prev_sel ? 5'd22 : 5'd9);
      check_output("toggle_valid", {4'd0, valid_q}, 5'd1);
      signal = ~signal;
    end
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_rst_q", result_q, 5'd0);
    check_output("mid_rst_valid", {4'd0, valid_q}, 5'd0);
    #4 rst_n = 1'b1;
    prev_sel = signal;
    @(posedge clk);
    #1;
    check_output("post_rst_q", result_q, prev_sel ? 5'd22 : 5'd9);
    check_output("post_rst_valid", {4'd0, valid_q}, 5'd1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
